branch_redirect_ctrl: RTL and testbench

- Owns the fetch PC register and sequences it from the static BTFN next-PC predictor. Backward branches and JAL are predicted taken; forward branches are predicted not-taken.
- Records every predicted control-flow instruction in an in-order FIFO and checks each one against execute-stage resolution.
- On a mispredict, redirects the PC, raises a pipeline flush and holds fetch for a fixed recovery window.
- Sits between the fetch stage (PC and predictor) and the execute stage (branch unit).

---
 rtl/branch_redirect_ctrl_pkg.sv | 11 +
 rtl/branch_redirect_ctrl_cf_pred_fifo.sv | 33 +++
 rtl/branch_redirect_ctrl.sv | 82 ++++++++
 tb/tb_branch_redirect_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg: shared opcode defines, FSM encoding and queue entry layout
package branch_redirect_ctrl_pkg;
   localparam logic [6:0] B_TYPE = 7'b1100011;
   localparam logic [6:0] J_JAL = 7'b1101111;
   localparam logic [31:0] INSTR_BYTES = 32'd4;
   typedef enum logic {ST_RUN = 1'b0, ST_RECOVER = 1'b1} state_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pred_next;
   } cf_entry_t;
endpackage

// File: rtl/branch_redirect_ctrl_cf_pred_fifo.sv
// cf_pred_fifo: in-order FIFO of predicted control-flow entries {pc, pred_next}
// Ports: clk, reset (async, active-high); push/din write the tail; pop retires the head;
// clear empties the queue and wins over push; dout is the head entry; count is occupancy.
module cf_pred_fifo #(
   parameter int DEPTH = 4,
   parameter int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  logic [63:0]   din,
   output logic [63:0]   dout,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [63:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk)
      if (push && !clear) mem[wr_ptr] <= din;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk or posedge reset)
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: fetch PC sequencing from a BTFN predictor with in-order mispredict recovery
// Ports: clk, reset (async, active-high); pc out to fetch; pred_pc/pred_is_cf from the predictor;
// fetch_ready from downstream; fetch_stall holds fetch; res_valid/res_taken/res_target from execute;
// flush kills younger work; mispredict_count saturates; queue_count is occupancy; res_err is sticky.
module branch_redirect_ctrl
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic [31:0]                  pc,
   input  logic [31:0]                  pred_pc,
   input  logic                         pred_is_cf,
   input  logic                         fetch_ready,
   output logic                         fetch_stall,
   input  logic                         res_valid,
   input  logic                         res_taken,
   input  logic [31:0]                  res_target,
   output logic                         flush,
   output logic [31:0]                  mispredict_count,
   output logic [$clog2(DEPTH+1)-1:0]   queue_count,
   output logic                         res_err
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int RW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   state_t state, state_nx;
   logic [RW-1:0] rcnt, rcnt_nx;
   logic [63:0] head_data;
   cf_entry_t head;
   logic adv, push, hit, mis, pop;
   logic [31:0] actual_next;
   assign head = head_data;
   assign fetch_stall = (state == ST_RECOVER) || (queue_count == FULL);
   assign adv = (state == ST_RUN) && !fetch_stall && fetch_ready;
   assign push = adv && pred_is_cf;
   // Resolutions arriving in RECOVER belong to flushed instructions and are dropped.
   assign hit = res_valid && (state == ST_RUN) && (queue_count != '0);
   assign actual_next = res_taken ? res_target : head.pc + INSTR_BYTES;
   assign mis = hit && (actual_next != head.pred_next);
   assign pop = hit && !mis;
   cf_pred_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (mis),
      .din   ({pc, pred_pc}),
      .dout  (head_data),
      .count (queue_count)
   );
   always_comb begin
      state_nx = state;
      rcnt_nx = rcnt;
      if (mis) begin
         state_nx = ST_RECOVER;
         rcnt_nx = RW'(FLUSH_CYCLES - 1);
      end else if (state == ST_RECOVER) begin
         state_nx = (rcnt == '0) ? ST_RUN : ST_RECOVER;
         rcnt_nx = (rcnt == '0) ? rcnt : rcnt - 1'b1;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= ST_RUN;
         rcnt <= '0;
         pc <= RESET_PC;
         flush <= 1'b0;
         mispredict_count <= '0;
         res_err <= 1'b0;
      end else begin
         state <= state_nx;
         rcnt <= rcnt_nx;
         pc <= mis ? actual_next : adv ? pred_pc : pc;
         flush <= mis;
         if (mis && mispredict_count != '1) mispredict_count <= mispredict_count + 32'd1;
         res_err <= res_err | (res_valid && (state == ST_RUN) && (queue_count == '0));
      end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: scoreboard bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic [31:0] pc, pred_pc, res_target, mispredict_count;
   logic pred_is_cf, fetch_ready, fetch_stall, res_valid, res_taken, flush, res_err;
   logic [2:0] queue_count;
   int n_tests = 0, n_fail = 0;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] cnt;
      logic [2:0]  qc;
      logic        fl;
      logic        st;
      logic        er;
   } exp_t;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] pn;
   } ent_t;
   exp_t sb[$];
   ent_t mq[$];
   logic [31:0] m_pc, m_cnt;
   logic m_flush, m_err;
   int m_rec;
   branch_redirect_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .pc               (pc),
      .pred_pc          (pred_pc),
      .pred_is_cf       (pred_is_cf),
      .fetch_ready      (fetch_ready),
      .fetch_stall      (fetch_stall),
      .res_valid        (res_valid),
      .res_taken        (res_taken),
      .res_target       (res_target),
      .flush            (flush),
      .mispredict_count (mispredict_count),
      .queue_count      (queue_count),
      .res_err          (res_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      m_pc = 32'h0;
      m_cnt = 32'h0;
      m_flush = 1'b0;
      m_err = 1'b0;
      m_rec = 0;
      mq.delete();
      sb.delete();
   endtask
   task automatic cyc(input logic rdy, input logic cf, input logic [31:0] ppc,
                      input logic rv, input logic rt, input logic [31:0] rtg);
      logic st, adv, hit, er, mis;
      logic [31:0] act;
      exp_t e;
      fetch_ready = rdy;
      pred_is_cf = cf;
      pred_pc = ppc;
      res_valid = rv;
      res_taken = rt;
      res_target = rtg;
      st = (m_rec > 0) || (mq.size() == 4);
      adv = !st && rdy;
      hit = rv && (mq.size() > 0) && (m_rec == 0);
      er = rv && (mq.size() == 0) && (m_rec == 0);
      act = 32'h0;
      mis = 1'b0;
      if (hit) begin
         act = rt ? rtg : mq[0].pc + 32'd4;
         mis = act != mq[0].pn;
      end
      m_err = m_err | er;
      if (mis) begin
         m_pc = act;
         mq.delete();
         m_flush = 1'b1;
         m_rec = 2;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
         m_flush = 1'b0;
         if (m_rec > 0) m_rec--;
         if (hit) void'(mq.pop_front());
         if (adv) begin
            if (cf) mq.push_back('{m_pc, ppc});
            m_pc = ppc;
         end
      end
      sb.push_back('{m_pc, m_cnt, 3'(mq.size()), m_flush, (m_rec > 0) || (mq.size() == 4), m_err});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sb_pc", pc, e.pc);
      chk("sb_qcount", 32'(queue_count), 32'(e.qc));
      chk("sb_flush", 32'(flush), 32'(e.fl));
      chk("sb_stall", 32'(fetch_stall), 32'(e.st));
      chk("sb_mcount", mispredict_count, e.cnt);
      chk("sb_err", 32'(res_err), 32'(e.er));
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"}, pc, 32'h0);
      chk({tag, "_flush"}, 32'(flush), 32'h0);
      chk({tag, "_stall"}, 32'(fetch_stall), 32'h0);
      chk({tag, "_mcount"}, mispredict_count, 32'h0);
      chk({tag, "_qcount"}, 32'(queue_count), 32'h0);
      chk({tag, "_err"}, 32'(res_err), 32'h0);
   endtask
   initial begin
      reset = 1'b1;
      {fetch_ready, pred_is_cf, res_valid, res_taken} = '0;
      pred_pc = 32'h0;
      res_target = 32'h0;
      model_reset();
      #2;
      chk_reset_vals("rst");
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1, 0, m_pc + 32'd4, 0, 0, 0);
      chk("seq_pc", pc, 32'hC);
      chk("seq_qcount", 32'(queue_count), 32'h0);
      cyc(1, 0, 32'h20, 0, 0, 0);
      cyc(1, 1, 32'h10, 0, 0, 0);
      chk("bwd_pc", pc, 32'h10);
      chk("bwd_qcount", 32'(queue_count), 32'h1);
      cyc(0, 0, 32'h0, 1, 1, 32'h10);
      chk("bwd_res_qcount", 32'(queue_count), 32'h0);
      chk("bwd_res_flush", 32'(flush), 32'h0);
      chk("bwd_res_mcount", mispredict_count, 32'h0);
      cyc(1, 0, 32'h40, 0, 0, 0);
      cyc(1, 1, 32'h44, 0, 0, 0);
      cyc(0, 0, 32'h0, 1, 1, 32'h80);
      chk("fwd_flush", 32'(flush), 32'h1);
      chk("fwd_pc", pc, 32'h80);
      chk("fwd_mcount", mispredict_count, 32'h1);
      chk("fwd_stall0", 32'(fetch_stall), 32'h1);
      cyc(1, 0, 32'h84, 0, 0, 0);
      chk("fwd_flush_once", 32'(flush), 32'h0);
      chk("fwd_stall1", 32'(fetch_stall), 32'h1);
      chk("fwd_hold_pc", pc, 32'h80);
      cyc(1, 0, 32'h84, 0, 0, 0);
      chk("fwd_stall_end", 32'(fetch_stall), 32'h0);
      cyc(1, 0, 32'h84, 0, 0, 0);
      chk("fwd_adv_pc", pc, 32'h84);
      for (int i = 0; i < 4; i++) cyc(1, 1, m_pc + 32'd4, 0, 0, 0);
      chk("full_qcount", 32'(queue_count), 32'h4);
      chk("full_stall", 32'(fetch_stall), 32'h1);
      cyc(1, 1, 32'h98, 0, 0, 0);
      chk("full_frozen_pc", pc, 32'h94);
      cyc(1, 1, 32'h98, 1, 0, 32'h0);
      chk("full_pop_qcount", 32'(queue_count), 32'h3);
      chk("full_pop_pc", pc, 32'h94);
      chk("full_release", 32'(fetch_stall), 32'h0);
      cyc(1, 0, 32'h98, 0, 0, 0);
      chk("full_adv_pc", pc, 32'h98);
      cyc(1, 1, 32'h9C, 1, 1, 32'h200);
      chk("mpush_qcount", 32'(queue_count), 32'h0);
      chk("mpush_pc", pc, 32'h200);
      chk("mpush_mcount", mispredict_count, 32'h2);
      cyc(1, 0, 32'h204, 1, 1, 32'h500);
      chk("stale_res_err", 32'(res_err), 32'h0);
      cyc(1, 0, 32'h204, 0, 0, 0);
      cyc(1, 0, m_pc + 32'd4, 1, 0, 0);
      chk("err_set", 32'(res_err), 32'h1);
      cyc(1, 0, m_pc + 32'd4, 0, 0, 0);
      chk("err_sticky", 32'(res_err), 32'h1);
      cyc(1, 1, m_pc + 32'd4, 0, 0, 0);
      force dut.mispredict_count = 32'hFFFF_FFFF;
      #1 release dut.mispredict_count;
      m_cnt = 32'hFFFF_FFFF;
      cyc(0, 0, 32'h0, 1, 1, 32'h300);
      chk("sat_mcount", mispredict_count, 32'hFFFF_FFFF);
      chk("sat_pc", pc, 32'h300);
      #2 reset = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      cyc(1, 0, 32'h4, 0, 0, 0);
      chk("post_rst_pc", pc, 32'h4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
